// File: rtl/fir_xifu_wb.sv
// fir_xifu_wb -- write-back stage of the FIR XIFU coprocessor.
//
// Holds one offloaded instruction taken from the EX/WB register until its
// commit decision is known, its memory transaction has returned (XFIRLW and
// XFIRSW), and the core has accepted the X-interface result. On completion it
// writes the XIFU register file (load data for XFIRLW, dot product for
// XFIRDOTP) and returns the post-incremented address to core GPR rs1
// (XFIRLW/XFIRSW).
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ex_*                     EX/WB entry handshake and payload
//   commit_*                 X-interface commit handshake (kill = 1 drops the entry)
//   mem_result_*             returned load/store data, id and bus error
//   rf_we_o/waddr_o/wdata_o  XIFU register-file write port (one-cycle strobe)
//   result_*                 X-interface result handshake and payload
//   busy_o                   an entry is held
//
// Build option
//   FIR_XIFU_WB_ERR_EN  when defined, a bus error on the memory result is
//                       reported on result_err_o and suppresses both the
//                       register-file write and the core GPR write. When
//                       undefined the error input is ignored.

module fir_xifu_wb #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RF_AW    = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [ID_WIDTH-1:0] ex_id_i,
    input  logic [1:0]          ex_instr_i,
    input  logic [XLEN-1:0]     ex_result_i,
    input  logic [RF_AW-1:0]    ex_rd_i,
    input  logic [4:0]          ex_rs1_i,

    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,

    input  logic                mem_result_valid_i,
    input  logic [ID_WIDTH-1:0] mem_result_id_i,
    input  logic [XLEN-1:0]     mem_result_rdata_i,
    input  logic                mem_result_err_i,

    output logic                rf_we_o,
    output logic [RF_AW-1:0]    rf_waddr_o,
    output logic [XLEN-1:0]     rf_wdata_o,

    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                result_err_o,

    output logic                busy_o
);

    typedef enum logic [1:0] {
        INSTR_NONE = 2'd0,
        INSTR_LW   = 2'd1,
        INSTR_SW   = 2'd2,
        INSTR_DOTP = 2'd3
    } instr_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;

    // Held entry
    logic [ID_WIDTH-1:0] id_q;
    instr_e              instr_q;
    logic [XLEN-1:0]     result_q;
    logic [RF_AW-1:0]    rd_q;
    logic [4:0]          rs1_q;
    logic                commit_q;
    logic                kill_q;
    logic                mem_done_q;
    logic [XLEN-1:0]     rdata_q;

    // Early-commit slot
    logic                early_v_q;
    logic [ID_WIDTH-1:0] early_id_q;
    logic                early_kill_q;

    // Register-file write port
    logic                rf_we_q;
    logic [RF_AW-1:0]    rf_waddr_q;
    logic [XLEN-1:0]     rf_wdata_q;

    logic                accept;
    logic                held;
    logic                deciding;
    logic [ID_WIDTH-1:0] cur_id;
    instr_e              cur_instr;
    logic [XLEN-1:0]     cur_result;
    logic [RF_AW-1:0]    cur_rd;
    logic                needs_mem;
    logic                commit_match;
    logic                early_hit;
    logic                early_store;
    logic                mem_match;
    logic                mem_hit;
    logic                seen;
    logic                kill;
    logic                mem_done;
    logic [XLEN-1:0]     rdata_now;
    logic                rf_we_d;
    logic [XLEN-1:0]     rf_wdata_d;
    logic                err_q;
    logic                err_cur;
    logic                resp;
    logic                mem_instr_q;

    // The accept cycle is evaluated exactly like a WAIT cycle, with the
    // incoming EX payload and the early-commit slot standing in for the
    // latched fields, so a fully satisfied entry skips WAIT entirely.
    always_comb begin
        accept      = (state_q == S_IDLE) && ex_valid_i && (instr_e'(ex_instr_i) != INSTR_NONE);
        held        = accept || (state_q != S_IDLE);
        deciding    = accept || (state_q == S_WAIT);

        cur_id      = (state_q == S_IDLE) ? ex_id_i              : id_q;
        cur_instr   = (state_q == S_IDLE) ? instr_e'(ex_instr_i) : instr_q;
        cur_result  = (state_q == S_IDLE) ? ex_result_i          : result_q;
        cur_rd      = (state_q == S_IDLE) ? ex_rd_i              : rd_q;
        needs_mem   = (cur_instr == INSTR_LW) || (cur_instr == INSTR_SW);

        commit_match = commit_valid_i && held && (commit_id_i == cur_id);
        early_store  = commit_valid_i && !commit_match;
        early_hit    = accept && early_v_q && (early_id_q == ex_id_i);

        mem_match    = mem_result_valid_i && held && (mem_result_id_i == cur_id);
        mem_hit      = mem_match && needs_mem;

        if (state_q == S_IDLE) begin
            seen = early_hit || commit_match;
            kill = commit_match ? commit_kill_i : early_kill_q;
        end else begin
            seen = commit_q || commit_match;
            kill = commit_match ? commit_kill_i : kill_q;
        end

        mem_done  = ((state_q == S_WAIT) && mem_done_q) || mem_hit;
        rdata_now = mem_hit ? mem_result_rdata_i : rdata_q;
    end

    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_wdata_d = (cur_instr == INSTR_LW) ? rdata_now : cur_result;
        unique case (state_q)
            S_IDLE, S_WAIT: begin
                if (deciding) begin
                    if (seen && !kill && (!needs_mem || mem_done)) begin
                        state_d = S_RESP;
                        rf_we_d = (cur_instr == INSTR_DOTP) ||
                                  ((cur_instr == INSTR_LW) && !err_cur);
                    end else if (seen && kill) begin
                        state_d = (needs_mem && !mem_done) ? S_DRAIN : S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_RESP: begin
                if (result_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_match) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            id_q         <= '0;
            instr_q      <= INSTR_NONE;
            result_q     <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            commit_q     <= 1'b0;
            kill_q       <= 1'b0;
            mem_done_q   <= 1'b0;
            rdata_q      <= '0;
            early_v_q    <= 1'b0;
            early_id_q   <= '0;
            early_kill_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q     <= ex_id_i;
                instr_q  <= instr_e'(ex_instr_i);
                result_q <= ex_result_i;
                rd_q     <= ex_rd_i;
                rs1_q    <= ex_rs1_i;
            end
            if (deciding) begin
                commit_q   <= seen;
                kill_q     <= kill;
                mem_done_q <= mem_done;
            end
            if (mem_hit) begin
                rdata_q <= mem_result_rdata_i;
            end
            // A fresh unmatched commit takes the slot even when the old
            // contents are consumed in the same cycle.
            if (early_store) begin
                early_v_q    <= 1'b1;
                early_id_q   <= commit_id_i;
                early_kill_q <= commit_kill_i;
            end else if (early_hit) begin
                early_v_q <= 1'b0;
            end
            rf_we_q <= rf_we_d;
            if (rf_we_d) begin
                rf_waddr_q <= cur_rd;
                rf_wdata_q <= rf_wdata_d;
            end
        end
    end

`ifdef FIR_XIFU_WB_ERR_EN
    always_comb begin
        err_cur = mem_hit ? mem_result_err_i : (accept ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (deciding) begin
            err_q <= err_cur;
        end
    end
`else
    logic unused_err;
    assign unused_err = mem_result_err_i;
    assign err_q      = 1'b0;
    assign err_cur    = 1'b0;
`endif

    assign resp        = (state_q == S_RESP);
    assign mem_instr_q = (instr_q == INSTR_LW) || (instr_q == INSTR_SW);

    assign ex_ready_o     = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);

    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;

    assign result_valid_o = resp;
    assign result_id_o    = resp ? id_q : '0;
    assign result_data_o  = (resp && mem_instr_q) ? result_q : '0;
    assign result_rd_o    = (resp && mem_instr_q) ? rs1_q : '0;
    assign result_we_o    = resp && mem_instr_q && !err_q;
    assign result_err_o   = resp && err_q;

endmodule

// File: tb/tb_fir_xifu_wb.sv
module tb_fir_xifu_wb;

`ifdef FIR_XIFU_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [3:0]  ex_id_i;
    logic [1:0]  ex_instr_i;
    logic [31:0] ex_result_i;
    logic [4:0]  ex_rd_i;
    logic [4:0]  ex_rs1_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        mem_result_valid_i;
    logic [3:0]  mem_result_id_i;
    logic [31:0] mem_result_rdata_i;
    logic        mem_result_err_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic        result_err_o;
    logic        busy_o;

    fir_xifu_wb #(.ID_WIDTH(4), .XLEN(32), .RF_AW(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_id_i(ex_id_i),
        .ex_instr_i(ex_instr_i), .ex_result_i(ex_result_i), .ex_rd_i(ex_rd_i),
        .ex_rs1_i(ex_rs1_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .mem_result_valid_i(mem_result_valid_i), .mem_result_id_i(mem_result_id_i),
        .mem_result_rdata_i(mem_result_rdata_i), .mem_result_err_i(mem_result_err_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_err_o(result_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    // instr: 1 LW, 2 SW, 3 DOTP. commit_off = -1 means commit one cycle
    // before the accept (early commit); otherwise cycle offset from accept.
    typedef struct {
        logic [1:0]  instr;
        logic [3:0]  id;
        logic [31:0] result;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        int          commit_off;
        bit          kill;
        int          mem_off;
        logic [31:0] rdata;
        bit          err;
        int          rdy_delay;
    } stim_t;

    // lat: cycle (after accept) of the first RESP cycle, or for a killed
    // entry the cycle in which the stage is idle again.
    typedef struct {
        bit          resp;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] data;
        bit          we;
        bit          err;
        int          lat;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl [8];

    function automatic stim_t mk_s(input logic [1:0] instr, input logic [3:0] id,
                                   input logic [31:0] result, input logic [4:0] rd,
                                   input logic [4:0] rs1, input int coff, input bit kill,
                                   input int moff, input logic [31:0] rdata,
                                   input bit err, input int d);
        stim_t s;
        s.instr = instr; s.id = id; s.result = result; s.rd = rd; s.rs1 = rs1;
        s.commit_off = coff; s.kill = kill; s.mem_off = moff; s.rdata = rdata;
        s.err = err; s.rdy_delay = d;
        return s;
    endfunction

    function automatic exp_t mk_e(input bit resp, input bit wr, input logic [31:0] wdata,
                                  input logic [31:0] data, input bit we, input bit err,
                                  input int lat);
        exp_t e;
        e.resp = resp; e.wr = wr; e.wdata = wdata; e.data = data; e.we = we;
        e.err = err; e.lat = lat;
        return e;
    endfunction

    // Reference: an entry completes one cycle after the later of its commit
    // and (for LW/SW) its memory return; a kill makes it disappear instead.
    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit   needs;
        bit   eerr;
        int   c;
        int   m;
        needs   = (s.instr != 2'd3);
        c       = (s.commit_off < 0) ? 0 : s.commit_off;
        m       = needs ? s.mem_off : 0;
        e.lat   = ((c > m) ? c : m) + 1;
        e.resp  = !s.kill;
        eerr    = ERR_EN && needs && s.err;
        e.wr    = e.resp && ((s.instr == 2'd3) || ((s.instr == 2'd1) && !eerr));
        e.wdata = (s.instr == 2'd1) ? s.rdata : s.result;
        e.data  = needs ? s.result : 32'h0;
        e.we    = needs && !eerr;
        e.err   = eerr;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        ex_valid_i         = 1'b0;
        ex_instr_i         = 2'd0;
        commit_valid_i     = 1'b0;
        commit_kill_i      = 1'b0;
        mem_result_valid_i = 1'b0;
        mem_result_err_i   = 1'b0;
        result_ready_i     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        clr();
    endtask

    task automatic drive_ex(input logic [1:0] instr, input logic [3:0] id,
                            input logic [31:0] result, input logic [4:0] rd,
                            input logic [4:0] rs1);
        ex_valid_i = 1'b1; ex_instr_i = instr; ex_id_i = id;
        ex_result_i = result; ex_rd_i = rd; ex_rs1_i = rs1;
    endtask

    task automatic drive_commit(input logic [3:0] id, input bit kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    endtask

    task automatic drive_mem(input logic [3:0] id, input logic [31:0] rdata, input bit err);
        mem_result_valid_i = 1'b1; mem_result_id_i = id;
        mem_result_rdata_i = rdata; mem_result_err_i = err;
    endtask

    task automatic run_txn(input stim_t s, input exp_t e);
        bit needs;
        bit busy_exp;
        bit valid_exp;
        int last;
        needs = (s.instr != 2'd3);
        last  = e.resp ? (e.lat + s.rdy_delay) : (e.lat - 1);

        tick();
        if (s.commit_off < 0) drive_commit(s.id, s.kill);
        @(negedge clk_i);
        chk("pre_ready", 32'(ex_ready_o), 32'd1);
        chk("pre_valid", 32'(result_valid_o), 32'd0);

        for (int cyc = 0; cyc <= last + 1; cyc++) begin
            tick();
            if (cyc == 0) drive_ex(s.instr, s.id, s.result, s.rd, s.rs1);
            if (cyc == s.commit_off) drive_commit(s.id, s.kill);
            if (needs && cyc == s.mem_off)
                drive_mem(s.id, s.rdata, s.err);
            else if ($urandom_range(0, 2) == 0)
                drive_mem(s.id ^ 4'h8, $urandom, 1'b0);
            result_ready_i = (cyc >= e.lat + s.rdy_delay);
            @(negedge clk_i);
            busy_exp  = (cyc >= 1) && (cyc <= last);
            valid_exp = e.resp && (cyc >= e.lat) && (cyc <= last);
            chk("busy", 32'(busy_o), 32'(busy_exp));
            chk("ex_ready", 32'(ex_ready_o), 32'(!busy_exp));
            chk("rf_we", 32'(rf_we_o), 32'(e.wr && cyc == e.lat));
            if (e.wr && cyc == e.lat) begin
                chk("rf_waddr", 32'(rf_waddr_o), 32'(s.rd));
                chk("rf_wdata", rf_wdata_o, e.wdata);
            end
            chk("res_valid", 32'(result_valid_o), 32'(valid_exp));
            if (valid_exp) begin
                chk("res_id", 32'(result_id_o), 32'(s.id));
                chk("res_data", result_data_o, e.data);
                chk("res_we", 32'(result_we_o), 32'(e.we));
                chk("res_err", 32'(result_err_o), 32'(e.err));
                if (needs) chk("res_rd", 32'(result_rd_o), 32'(s.rs1));
            end
        end
    endtask

    initial begin
        stim_t s;
        rst_ni = 1'b0;
        clr();
        ex_id_i = '0; ex_result_i = '0; ex_rd_i = '0; ex_rs1_i = '0;
        commit_id_i = '0; mem_result_id_i = '0; mem_result_rdata_i = '0;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rf", {rf_wdata_o[26:0], rf_waddr_o}, 32'd0);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_res", {result_data_o[15:0], result_id_o, result_rd_o, result_valid_o,
                        result_we_o, result_err_o, 4'd0}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        tbl[0].s = mk_s(2'd3, 4'd3, 32'h0000_0A00, 5'd7, 5'd0, 0, 1'b0, 0, 32'h0, 1'b0, 0);
        tbl[0].e = mk_e(1'b1, 1'b1, 32'h0000_0A00, 32'h0, 1'b0, 1'b0, 1);
        tbl[1].s = mk_s(2'd1, 4'd1, 32'h0000_1004, 5'd4, 5'd10, 1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 0);
        tbl[1].e = mk_e(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1004, 1'b1, 1'b0, 4);
        tbl[2].s = mk_s(2'd2, 4'd2, 32'h0000_2000, 5'd0, 5'd12, -1, 1'b0, 0, 32'h0, 1'b0, 0);
        tbl[2].e = mk_e(1'b1, 1'b0, 32'h0, 32'h0000_2000, 1'b1, 1'b0, 1);
        tbl[3].s = mk_s(2'd2, 4'd5, 32'h0000_3000, 5'd0, 5'd6, 1, 1'b1, 3, 32'h0, 1'b0, 0);
        tbl[3].e = mk_e(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4);
        tbl[4].s = mk_s(2'd3, 4'd7, 32'h0000_1234, 5'd9, 5'd0, 0, 1'b0, 0, 32'h0, 1'b0, 4);
        tbl[4].e = mk_e(1'b1, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1);
        tbl[5].s = mk_s(2'd1, 4'd4, 32'h0000_2008, 5'd2, 5'd11, 0, 1'b0, 1, 32'h1234_5678, 1'b1, 0);
        if (ERR_EN) tbl[5].e = mk_e(1'b1, 1'b0, 32'h0, 32'h0000_2008, 1'b0, 1'b1, 2);
        else        tbl[5].e = mk_e(1'b1, 1'b1, 32'h1234_5678, 32'h0000_2008, 1'b1, 1'b0, 2);
        tbl[6].s = mk_s(2'd3, 4'd8, 32'h0000_0042, 5'd3, 5'd0, -1, 1'b1, 0, 32'h0, 1'b0, 0);
        tbl[6].e = mk_e(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
        tbl[7].s = mk_s(2'd1, 4'hE, 32'h0000_0044, 5'd30, 5'd31, 2, 1'b0, 0, 32'hCAFE_0001, 1'b0, 1);
        tbl[7].e = mk_e(1'b1, 1'b1, 32'hCAFE_0001, 32'h0000_0044, 1'b1, 1'b0, 3);

        for (int i = 0; i < 8; i++) run_txn(tbl[i].s, tbl[i].e);

        // Early-commit slot overwritten by a newer commit for the same id.
        tick(); drive_commit(4'd6, 1'b1);
        tick(); drive_commit(4'd6, 1'b0);
        tick(); drive_ex(2'd3, 4'd6, 32'h55, 5'd3, 5'd0);
        tick(); result_ready_i = 1'b1;
        @(negedge clk_i);
        chk("ovr_valid", 32'(result_valid_o), 32'd1);
        chk("ovr_rf_we", 32'(rf_we_o), 32'd1);
        chk("ovr_wdata", rf_wdata_o, 32'h55);

        // Commit for another id while an entry is held is kept for later.
        tick(); drive_ex(2'd1, 4'd1, 32'h40, 5'd1, 5'd3);
        tick(); drive_commit(4'd9, 1'b0);
        @(negedge clk_i);
        chk("held_busy", 32'(busy_o), 32'd1);
        tick(); drive_commit(4'd1, 1'b0); drive_mem(4'd1, 32'h77, 1'b0);
        tick(); result_ready_i = 1'b1;
        @(negedge clk_i);
        chk("held_rf_wdata", rf_wdata_o, 32'h77);
        tick(); drive_ex(2'd3, 4'd9, 32'h99, 5'd5, 5'd0);
        tick(); result_ready_i = 1'b1;
        @(negedge clk_i);
        chk("stored_valid", 32'(result_valid_o), 32'd1);
        chk("stored_id", 32'(result_id_o), 32'd9);

        // Reset mid-operation drops the entry and the early-commit slot.
        tick(); drive_commit(4'd11, 1'b0);
        tick(); drive_ex(2'd1, 4'd2, 32'h80, 5'd2, 5'd4); drive_commit(4'd2, 1'b0);
        tick();
        @(negedge clk_i);
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        chk("rst_async_ready", 32'(ex_ready_o), 32'd1);
        tick(); rst_ni = 1'b1; drive_mem(4'd2, 32'h1111, 1'b0);
        @(negedge clk_i);
        chk("rst_no_rf", 32'(rf_we_o), 32'd0);
        tick(); drive_ex(2'd3, 4'd11, 32'h5, 5'd1, 5'd0);
        tick();
        @(negedge clk_i);
        chk("rst_slot_clear", {31'd0, busy_o}, 32'd1);
        chk("rst_slot_noval", 32'(result_valid_o), 32'd0);
        tick(); drive_commit(4'd11, 1'b1);
        tick();
        @(negedge clk_i);
        chk("kill_idle", 32'(busy_o), 32'd0);

        for (int i = 0; i < 80; i++) begin
            s.instr      = 2'(int'($urandom_range(1, 3)));
            s.id         = 4'($urandom);
            s.result     = $urandom;
            s.rd         = 5'($urandom);
            s.rs1        = 5'($urandom);
            s.commit_off = int'($urandom_range(0, 4)) - 1;
            s.kill       = ($urandom_range(0, 3) == 0);
            s.mem_off    = int'($urandom_range(0, 4));
            s.rdata      = $urandom;
            s.err        = ($urandom_range(0, 3) == 0);
            s.rdy_delay  = int'($urandom_range(0, 3));
            run_txn(s, predict(s));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
